nrs_seq_ctrl_rx: RTL and testbench

NRS_SEQ_CTRL_RX -- requirements
Module: nrs_seq_ctrl_rx

---
 rtl/nrs_pkg.sv | 22 ++
 rtl/nrs_bank_ctrl.sv | 39 +++
 rtl/nrs_seq_ctrl_rx.sv | 180 ++++++++++++++++++
 tb/tb_nrs_seq_ctrl_rx.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/nrs_pkg.sv
// Shared definitions for the NRS Gold-sequence receive controller:
// parameter defaults, controller state encoding and a ceil-divide helper.
package nrs_pkg;

    localparam int NC_DEF   = 1600;
    localparam int PAR_DEF  = 1;
    localparam int EVAL_DEF = 4;
    localparam int RUNS_DEF = 4;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_REQ_CINIT = 3'd1,
        ST_SEED      = 3'd2,
        ST_SHIFT     = 3'd3,
        ST_EVAL      = 3'd4
    } nrs_state_e;

    function automatic int ceil_div(input int num, input int den);
        return (num + den - 1) / den;
    endfunction

endpackage

// File: rtl/nrs_bank_ctrl.sv
// Ping-pong bank bookkeeping: per-bank ready flags, the bank being written,
// and consumer acknowledges. A completion beats an ack to the same bank.
module nrs_bank_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic       complete,
    input  logic       est_ack,
    input  logic       ack_bank,
    output logic [1:0] bank_ready,
    output logic       wr_bank
);

    logic [1:0] ready_q, ready_d;
    logic [1:0] set_s, clr_s;
    logic       wr_bank_q, wr_bank_d;

    // Clear acked bank first, then apply completion so the set wins.
    always_comb begin
        set_s     = complete ? (2'b01 << wr_bank_q) : 2'b00;
        clr_s     = est_ack  ? (2'b01 << ack_bank)  : 2'b00;
        ready_d   = (ready_q & ~clr_s) | set_s;
        wr_bank_d = wr_bank_q ^ complete;
    end

    // Bank state registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ready_q   <= 2'b00;
            wr_bank_q <= 1'b0;
        end else begin
            ready_q   <= ready_d;
            wr_bank_q <= wr_bank_d;
        end
    end

    assign bank_ready = ready_q;
    assign wr_bank    = wr_bank_q;

endmodule

// File: rtl/nrs_seq_ctrl_rx.sv
// NRS receive sequence controller: requests cinit, seeds and warms up the
// Gold LFSRs, then writes EVAL words per run into the current ping-pong bank.
module nrs_seq_ctrl_rx
    import nrs_pkg::*;
#(
    parameter  int NC     = NC_DEF,
    parameter  int PAR    = PAR_DEF,
    parameter  int EVAL   = EVAL_DEF,
    parameter  int RUNS   = RUNS_DEF,
    localparam int ADDR_W = $clog2(2 * RUNS * EVAL),
    localparam int RUN_W  = (RUNS > 1) ? $clog2(RUNS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              new_frame,
    input  logic              cinit_valid,
    input  logic              est_ack,
    input  logic              ack_bank,
    output logic              cinit_req,
    output logic              init_x1,
    output logic              init_x2,
    output logic              shift_en,
    output logic              out_valid,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [RUN_W-1:0]  run_idx,
    output logic              first_run,
    output logic              last_run,
    output logic [1:0]        bank_ready,
    output logic              busy,
    output logic              overrun
);

    localparam int W     = ceil_div(NC, PAR);
    localparam int CNT_W = $clog2(((W > EVAL) ? W : EVAL) + 1);
    localparam int SPAN  = RUNS * EVAL;

    nrs_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [RUN_W-1:0]  run_q, run_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] base_s;
    logic              overrun_q, overrun_d;
    logic              complete_s, wr_bank_s;
    logic [1:0]        bank_ready_s;
    logic              cinit_req_q, init_q, shift_en_q, wr_q, busy_q;

    assign base_s = wr_bank_s ? ADDR_W'(SPAN) : {ADDR_W{1'b0}};

    // Sequencing; a new_frame while busy overrides whatever the state wanted.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        run_d      = run_q;
        addr_d     = addr_q;
        overrun_d  = overrun_q;
        complete_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if ((start || new_frame) && !bank_ready_s[wr_bank_s]) begin
                    state_d = ST_REQ_CINIT;
                    run_d   = {RUN_W{1'b0}};
                    addr_d  = base_s;
                end else if (start) begin
                    overrun_d = 1'b1;
                end else begin
                    overrun_d = overrun_q;
                end
            end
            ST_REQ_CINIT: begin
                if (cinit_valid) begin
                    state_d = ST_SEED;
                end else begin
                    state_d = ST_REQ_CINIT;
                end
            end
            ST_SEED: begin
                state_d = ST_SHIFT;
                cnt_d   = {CNT_W{1'b0}};
            end
            ST_SHIFT: begin
                if (cnt_q == CNT_W'(W - 1)) begin
                    state_d = ST_EVAL;
                    cnt_d   = {CNT_W{1'b0}};
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_EVAL: begin
                addr_d = addr_q + ADDR_W'(1);
                if (cnt_q == CNT_W'(EVAL - 1)) begin
                    cnt_d = {CNT_W{1'b0}};
                    if (run_q == RUN_W'(RUNS - 1)) begin
                        state_d    = ST_IDLE;
                        complete_s = 1'b1;
                    end else begin
                        state_d = ST_REQ_CINIT;
                        run_d   = run_q + RUN_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (state_q != ST_IDLE) begin
            if (start) begin
                overrun_d = 1'b1;
            end else begin
                overrun_d = overrun_d;
            end
            if (new_frame) begin
                state_d    = ST_REQ_CINIT;
                run_d      = {RUN_W{1'b0}};
                addr_d     = base_s;
                cnt_d      = {CNT_W{1'b0}};
                complete_s = 1'b0;
            end else begin
                complete_s = complete_s;
            end
        end else begin
            complete_s = complete_s;
        end
    end

    // Controller FSM with strobes registered from the next state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= {CNT_W{1'b0}};
            run_q       <= {RUN_W{1'b0}};
            addr_q      <= {ADDR_W{1'b0}};
            overrun_q   <= 1'b0;
            cinit_req_q <= 1'b0;
            init_q      <= 1'b0;
            shift_en_q  <= 1'b0;
            wr_q        <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            run_q       <= run_d;
            addr_q      <= addr_d;
            overrun_q   <= overrun_d;
            cinit_req_q <= (state_d == ST_REQ_CINIT);
            init_q      <= (state_d == ST_SEED);
            shift_en_q  <= (state_d == ST_SHIFT) || (state_d == ST_EVAL);
            wr_q        <= (state_d == ST_EVAL);
            busy_q      <= (state_d != ST_IDLE);
        end
    end

    nrs_bank_ctrl u_bank (
        .clk        (clk),
        .rst        (rst),
        .complete   (complete_s),
        .est_ack    (est_ack),
        .ack_bank   (ack_bank),
        .bank_ready (bank_ready_s),
        .wr_bank    (wr_bank_s)
    );

    assign cinit_req  = cinit_req_q;
    assign init_x1    = init_q;
    assign init_x2    = init_q;
    assign shift_en   = shift_en_q;
    assign out_valid  = wr_q;
    assign wr_en      = wr_q;
    assign wr_addr    = addr_q;
    assign run_idx    = run_q;
    assign first_run  = (run_q == {RUN_W{1'b0}});
    assign last_run   = (run_q == RUN_W'(RUNS - 1));
    assign bank_ready = bank_ready_s;
    assign busy       = busy_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_nrs_seq_ctrl_rx.sv
// Directed-random bench for nrs_seq_ctrl_rx with a phase/bank reference model.
module tb_nrs_seq_ctrl_rx;

    localparam int NC_N   = 1600;
    localparam int EVAL_N = 4;
    localparam int RUNS_N = 4;
    localparam int SPAN   = RUNS_N * EVAL_N;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, start, new_frame, cinit_valid, est_ack, ack_bank;
    logic       cinit_req, init_x1, init_x2, shift_en, out_valid, wr_en;
    logic       first_run, last_run, busy, overrun;
    logic [4:0] wr_addr;
    logic [1:0] run_idx, bank_ready;

    logic       p_start, p_cv;
    logic [1:0] px_req, px_x1, px_x2, px_se, px_ov, px_we, px_fr, px_lr, px_busy, px_orun;
    logic [4:0] px_addr [2];
    logic [1:0] px_run [2];
    logic [1:0] px_rdy [2];

    int         vectors = 0;
    int         miscompares = 0;
    logic [1:0] m_ready;
    logic       m_bank;

    nrs_seq_ctrl_rx u_dut (
        .clk(clk), .rst(rst), .start(start), .new_frame(new_frame),
        .cinit_valid(cinit_valid), .est_ack(est_ack), .ack_bank(ack_bank),
        .cinit_req(cinit_req), .init_x1(init_x1), .init_x2(init_x2),
        .shift_en(shift_en), .out_valid(out_valid), .wr_en(wr_en),
        .wr_addr(wr_addr), .run_idx(run_idx), .first_run(first_run),
        .last_run(last_run), .bank_ready(bank_ready), .busy(busy), .overrun(overrun)
    );

    for (genvar g = 0; g < 2; g++) begin : g_par
        nrs_seq_ctrl_rx #(.PAR((g == 0) ? 4 : 8)) u_dut (
            .clk(clk), .rst(rst), .start(p_start), .new_frame(1'b0),
            .cinit_valid(p_cv), .est_ack(1'b0), .ack_bank(1'b0),
            .cinit_req(px_req[g]), .init_x1(px_x1[g]), .init_x2(px_x2[g]),
            .shift_en(px_se[g]), .out_valid(px_ov[g]), .wr_en(px_we[g]),
            .wr_addr(px_addr[g]), .run_idx(px_run[g]), .first_run(px_fr[g]),
            .last_run(px_lr[g]), .bank_ready(px_rdy[g]), .busy(px_busy[g]),
            .overrun(px_orun[g])
        );
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One run: cinit handshake after dly cycles, then phase lengths and addresses.
    task automatic do_run(input int r, input int dly, input bit ack_end, input bit abort);
        int base, t, nshift, neval, last;
        base = m_bank * SPAN;
        chk("run_idx", run_idx, r);
        chk("first_last", {first_run, last_run}, {r == 0, r == RUNS_N - 1});
        chk("run_addr", wr_addr, base + r * EVAL_N);
        repeat (dly) begin
            chk("cinit_req_wait", cinit_req, 1);
            tick();
        end
        chk("cinit_req", cinit_req, 1);
        cinit_valid = 1'b1;
        tick();
        cinit_valid = 1'b0;
        chk("seed", {init_x1, init_x2, shift_en, out_valid}, 4'b1100);
        t = 1; nshift = 0; neval = 0; last = 0;
        for (int i = 0; i < NC_N + 20; i++) begin
            tick();
            est_ack = 1'b0;
            t++;
            if (!shift_en) break;
            if (!out_valid) begin
                nshift++;
            end else begin
                chk("wr_addr", {wr_en, wr_addr}, {1'b1, 5'(base + r * EVAL_N + neval)});
                neval++;
                last = t;
                if (abort && neval == 1) begin
                    new_frame = 1'b1;
                    tick();
                    new_frame = 1'b0;
                    chk("abort_state", {cinit_req, shift_en, busy}, 3'b101);
                    chk("abort_run_idx", run_idx, 0);
                    chk("abort_addr", wr_addr, base);
                    chk("abort_overrun", overrun, 0);
                    chk("abort_ready", bank_ready, m_ready);
                    return;
                end
                if (ack_end && r == RUNS_N - 1 && neval == EVAL_N) begin
                    est_ack  = 1'b1;
                    ack_bank = 1'b0;
                end
            end
        end
        chk("shift_len", nshift, NC_N);
        chk("eval_len", neval, EVAL_N);
        chk("latency", last, 1 + NC_N + EVAL_N);
    endtask

    // Full subframe into the model's current bank, optionally aborted once.
    task automatic subframe(input int dly0, input bit ack_end, input int abort_run);
        int  r;
        bit  aborted;
        chk("pre_ready", bank_ready, m_ready);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_busy", {busy, cinit_req}, 2'b11);
        r = 0;
        aborted = 1'b0;
        while (r < RUNS_N) begin
            if (r == abort_run && !aborted) begin
                do_run(r, $urandom_range(0, 4), 1'b0, 1'b1);
                aborted = 1'b1;
                r = 0;
            end else begin
                do_run(r, (r == 0) ? dly0 : int'($urandom_range(0, 4)), ack_end, 1'b0);
                r++;
            end
        end
        if (ack_end) m_ready[0] = 1'b0;
        m_ready[m_bank] = 1'b1;
        m_bank = ~m_bank;
        chk("done_idle", {busy, wr_en}, 2'b00);
        chk("done_ready", bank_ready, m_ready);
    endtask

    task automatic ack(input logic bank);
        est_ack  = 1'b1;
        ack_bank = bank;
        tick();
        est_ack  = 1'b0;
        m_ready[bank] = 1'b0;
        chk("ack_ready", bank_ready, m_ready);
    endtask

    initial begin
        int c4, c8;
        bit s4, s8;
        rst = 1'b1; start = 1'b0; new_frame = 1'b0; cinit_valid = 1'b0;
        est_ack = 1'b0; ack_bank = 1'b0; p_start = 1'b0; p_cv = 1'b0;
        m_ready = 2'b00; m_bank = 1'b0;
        #2 rst = 1'b0;
        repeat (3) tick();
        chk("rst_strobes", {cinit_req, init_x1, init_x2, shift_en, out_valid, wr_en, busy}, 7'd0);
        chk("rst_state", {bank_ready, overrun, wr_addr, run_idx}, 10'd0);
        chk("rst_first_last", {first_run, last_run}, 2'b10);
        rst = 1'b1;
        tick();

        subframe(3, 1'b0, -1);
        chk("ready_A", bank_ready, 2'b01);
        est_ack = 1'b1; ack_bank = 1'b1;
        tick();
        est_ack = 1'b0;
        chk("ack_nonready", bank_ready, 2'b01);

        subframe($urandom_range(0, 4), 1'b0, -1);
        chk("ready_B", bank_ready, 2'b11);
        repeat ($urandom_range(1, 5)) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("overrun_set", {overrun, busy, cinit_req}, 3'b100);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("overrun_idle", {wr_en, busy, overrun}, 3'b001);
        end
        chk("overrun_ready", bank_ready, 2'b11);

        ack(1'b0);
        subframe($urandom_range(0, 4), 1'b1, -1);
        chk("set_wins", bank_ready, 2'b11);
        ack(1'b1);

        start = 1'b1;
        tick();
        start = 1'b0;
        cinit_valid = 1'b1;
        tick();
        cinit_valid = 1'b0;
        repeat ($urandom_range(20, 300)) tick();
        chk("pre_rst_shift", {shift_en, out_valid}, 2'b10);
        #3 rst = 1'b0;
        #1;
        chk("midrun_rst_strobes", {cinit_req, init_x1, init_x2, shift_en, out_valid, wr_en, busy}, 7'd0);
        chk("midrun_rst_state", {bank_ready, overrun, wr_addr, run_idx}, 10'd0);
        tick();
        tick();
        rst = 1'b1;
        m_ready = 2'b00; m_bank = 1'b0;
        tick();

        subframe($urandom_range(0, 4), 1'b0, 2);
        chk("ready_after_abort", bank_ready, 2'b01);

        p_cv = 1'b1;
        p_start = 1'b1;
        tick();
        p_start = 1'b0;
        c4 = 0; c8 = 0; s4 = 1'b0; s8 = 1'b0;
        for (int i = 0; i < 600 && !(s4 && s8); i++) begin
            tick();
            if (!s4) begin
                if (px_ov[0]) s4 = 1'b1;
                else if (px_se[0]) c4++;
            end
            if (!s8) begin
                if (px_ov[1]) s8 = 1'b1;
                else if (px_se[1]) c8++;
            end
        end
        chk("par4_eval_seen", s4, 1);
        chk("par8_eval_seen", s8, 1);
        chk("par4_shift_len", c4, (NC_N + 3) / 4);
        chk("par8_shift_len", c8, (NC_N + 7) / 8);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
